// File: rtl/rs_pkg.sv
// Shared types and constants for the reservation-station slice.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package rs_pkg;

  // Default widths; stations may override them through their own parameters.
  localparam int RS_TAG_W  = 4;
  localparam int RS_DATA_W = 32;
  localparam int RS_OP_W   = 5;

  // A zero tag means the operand value is already held in the entry.
  localparam int TAG_NONE  = 0;

  typedef logic [RS_TAG_W-1:0]  tag_t;
  typedef logic [RS_DATA_W-1:0] data_t;
  typedef logic [RS_OP_W-1:0]   op_t;

  // One station slot at the default widths.
  typedef struct packed {
    logic  busy;
    op_t   op;
    tag_t  qj;
    tag_t  qk;
    data_t vj;
    data_t vk;
    tag_t  dest;
  } rs_entry_t;

endpackage

// File: rtl/rs_age_select.sv
// Oldest-first selector over a ready vector and an age matrix.
// Latency: combinational.
// Backpressure: none; the caller gates the grant with its own handshake.
module rs_age_select #(
  parameter int DEPTH = 16
) (
  input  logic [DEPTH-1:0]            ready,
  // older[j][i] = 1 means entry j was allocated before entry i.
  input  logic [DEPTH-1:0][DEPTH-1:0] older,
  output logic [DEPTH-1:0]            grant,
  output logic [$clog2(DEPTH)-1:0]    grant_idx,
  output logic                        has_grant
);

  localparam int IW = $clog2(DEPTH);

  // A ready entry wins unless some other ready entry is older than it.
  always_comb begin
    grant = '0;
    for (int i = 0; i < DEPTH; i++) begin
      grant[i] = ready[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && ready[j] && older[j][i]) grant[i] = 1'b0;
      end
    end
  end

  // One-hot to binary; the grant is at most one-hot so OR-ing is safe.
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) grant_idx = grant_idx | IW'(i);
    end
  end

  assign has_grant = |grant;

endmodule

// File: rtl/rs_common.sv
// Lowest-index priority encoder, used for vacancy search.
// Latency: combinational.
// Backpressure: none; pure function of the request vector.
module rs_common #(
  parameter int N = 16
) (
  input  logic [N-1:0]         req,
  output logic [$clog2(N)-1:0] idx,
  output logic                 found
);

  localparam int IW = $clog2(N);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

  // Any request at all.
  assign found = |req;

endmodule

// File: rtl/rs_age_station.sv
// Reservation station: holds operands, snoops the CDB, issues the oldest ready entry.
// Latency: alloc with ready operands or CDB wakeup -> issuable the following cycle.
// Backpressure: alloc_ready_out drops at DEPTH entries; winner held while issue_ready_in is low.
module rs_age_station
  import rs_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int TAG_W  = RS_TAG_W,
  parameter int DATA_W = RS_DATA_W,
  parameter int OP_W   = RS_OP_W
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rdy_in,
  input  logic                       flush_in,
  input  logic                       alloc_valid_in,
  output logic                       alloc_ready_out,
  input  logic [OP_W-1:0]            alloc_op_in,
  input  logic [TAG_W-1:0]           alloc_qj_in,
  input  logic [TAG_W-1:0]           alloc_qk_in,
  input  logic [DATA_W-1:0]          alloc_vj_in,
  input  logic [DATA_W-1:0]          alloc_vk_in,
  input  logic [TAG_W-1:0]           alloc_dest_in,
  input  logic                       cdb_valid_in,
  input  logic [TAG_W-1:0]           cdb_tag_in,
  input  logic [DATA_W-1:0]          cdb_value_in,
  output logic                       issue_valid_out,
  input  logic                       issue_ready_in,
  output logic [OP_W-1:0]            issue_op_out,
  output logic [DATA_W-1:0]          issue_vj_out,
  output logic [DATA_W-1:0]          issue_vk_out,
  output logic [TAG_W-1:0]           issue_dest_out,
  output logic [$clog2(DEPTH+1)-1:0] count_out,
  output logic                       almost_full_out
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam logic [TAG_W-1:0] TAG_ZERO = TAG_W'(TAG_NONE);

  // Same layout as rs_entry_t, resized by this instance's parameters.
  typedef struct packed {
    logic              busy;
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  qj;
    logic [TAG_W-1:0]  qk;
    logic [DATA_W-1:0] vj;
    logic [DATA_W-1:0] vk;
    logic [TAG_W-1:0]  dest;
  } entry_t;

  entry_t                     ent [DEPTH];
  logic [DEPTH-1:0][DEPTH-1:0] older;
  logic [CW-1:0]              count_q;
  logic [DEPTH-1:0]           busy_v, vacant_v, ready_v, grant;
  logic [IW-1:0]              win_idx, free_idx;
  logic                       has_grant, has_free;
  logic                       alloc_fire, deq_fire;
  logic                       byp_j, byp_k;
  entry_t                     new_ent;

  // Per-slot status from registered state only; same-cycle CDB does not count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      busy_v[i]   = ent[i].busy;
      vacant_v[i] = ~ent[i].busy;
      ready_v[i]  = ent[i].busy && ent[i].qj == TAG_ZERO && ent[i].qk == TAG_ZERO;
    end
  end

  rs_common #(.N(DEPTH)) u_vacancy (
    .req   (vacant_v),
    .idx   (free_idx),
    .found (has_free)
  );

  rs_age_select #(.DEPTH(DEPTH)) u_select (
    .ready     (ready_v),
    .older     (older),
    .grant     (grant),
    .grant_idx (win_idx),
    .has_grant (has_grant)
  );

  assign count_out       = count_q;
  assign alloc_ready_out = count_q < CW'(DEPTH);
  assign almost_full_out = count_q == CW'(DEPTH - 1);
  assign issue_valid_out = has_grant & rdy_in & ~flush_in;
  assign issue_op_out    = ent[win_idx].op;
  assign issue_vj_out    = ent[win_idx].vj;
  assign issue_vk_out    = ent[win_idx].vk;
  assign issue_dest_out  = ent[win_idx].dest;
  assign deq_fire        = issue_valid_out & issue_ready_in & grant[win_idx];
  assign alloc_fire      = alloc_valid_in & alloc_ready_out & has_free & rdy_in & ~flush_in;

  // Incoming entry, with operands that the current CDB broadcast already resolves.
  always_comb begin
    byp_j        = cdb_valid_in && alloc_qj_in != TAG_ZERO && alloc_qj_in == cdb_tag_in;
    byp_k        = cdb_valid_in && alloc_qk_in != TAG_ZERO && alloc_qk_in == cdb_tag_in;
    new_ent.busy = 1'b1;
    new_ent.op   = alloc_op_in;
    new_ent.qj   = byp_j ? TAG_ZERO : alloc_qj_in;
    new_ent.qk   = byp_k ? TAG_ZERO : alloc_qk_in;
    new_ent.vj   = byp_j ? cdb_value_in : alloc_vj_in;
    new_ent.vk   = byp_k ? cdb_value_in : alloc_vk_in;
    new_ent.dest = alloc_dest_in;
  end

  // Entry, age and occupancy state: flush wins, then wakeup, dequeue and alloc together.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      older   <= '0;
      count_q <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        for (int i = 0; i < DEPTH; i++) ent[i].busy <= 1'b0;
        older   <= '0;
        count_q <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (ent[i].busy && cdb_valid_in) begin
            if (ent[i].qj != TAG_ZERO && ent[i].qj == cdb_tag_in) begin
              ent[i].qj <= TAG_ZERO;
              ent[i].vj <= cdb_value_in;
            end
            if (ent[i].qk != TAG_ZERO && ent[i].qk == cdb_tag_in) begin
              ent[i].qk <= TAG_ZERO;
              ent[i].vk <= cdb_value_in;
            end
          end
        end
        if (deq_fire) ent[win_idx].busy <= 1'b0;
        if (alloc_fire) begin
          // The vacant slot never equals the winner, so these writes do not collide.
          ent[free_idx]   <= new_ent;
          older[free_idx] <= '0;
          for (int j = 0; j < DEPTH; j++) begin
            if (j != int'(free_idx)) older[j][free_idx] <= busy_v[j];
          end
        end
        count_q <= count_q + CW'(alloc_fire) - CW'(deq_fire);
      end
    end
  end

endmodule

// File: tb/tb_rs_age_station.sv
// Directed bench for rs_age_station with hand-computed expectations.
// Latency: inputs driven 1 ns after the rising edge, outputs sampled 1 ns later.
// Backpressure: issue_ready_in driven explicitly per vector.
module tb_rs_age_station;

  localparam int DEPTH  = 16;
  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;
  localparam int OP_W   = 5;
  localparam int CW     = $clog2(DEPTH + 1);

  logic              clk_in, rst_in, rdy_in, flush_in;
  logic              alloc_valid_in, alloc_ready_out;
  logic [OP_W-1:0]   alloc_op_in;
  logic [TAG_W-1:0]  alloc_qj_in, alloc_qk_in, alloc_dest_in;
  logic [DATA_W-1:0] alloc_vj_in, alloc_vk_in;
  logic              cdb_valid_in;
  logic [TAG_W-1:0]  cdb_tag_in;
  logic [DATA_W-1:0] cdb_value_in;
  logic              issue_valid_out, issue_ready_in;
  logic [OP_W-1:0]   issue_op_out;
  logic [DATA_W-1:0] issue_vj_out, issue_vk_out;
  logic [TAG_W-1:0]  issue_dest_out;
  logic [CW-1:0]     count_out;
  logic              almost_full_out;

  int n_cmp = 0;
  int n_bad = 0;

  rs_age_station #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .OP_W(OP_W)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .rdy_in          (rdy_in),
    .flush_in        (flush_in),
    .alloc_valid_in  (alloc_valid_in),
    .alloc_ready_out (alloc_ready_out),
    .alloc_op_in     (alloc_op_in),
    .alloc_qj_in     (alloc_qj_in),
    .alloc_qk_in     (alloc_qk_in),
    .alloc_vj_in     (alloc_vj_in),
    .alloc_vk_in     (alloc_vk_in),
    .alloc_dest_in   (alloc_dest_in),
    .cdb_valid_in    (cdb_valid_in),
    .cdb_tag_in      (cdb_tag_in),
    .cdb_value_in    (cdb_value_in),
    .issue_valid_out (issue_valid_out),
    .issue_ready_in  (issue_ready_in),
    .issue_op_out    (issue_op_out),
    .issue_vj_out    (issue_vj_out),
    .issue_vk_out    (issue_vk_out),
    .issue_dest_out  (issue_dest_out),
    .count_out       (count_out),
    .almost_full_out (almost_full_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic put(input int op, input int qj, input int qk, input int vj, input int vk, input int dest);
    alloc_valid_in = 1'b1;
    alloc_op_in    = OP_W'(op);
    alloc_qj_in    = TAG_W'(qj);
    alloc_qk_in    = TAG_W'(qk);
    alloc_vj_in    = DATA_W'(vj);
    alloc_vk_in    = DATA_W'(vk);
    alloc_dest_in  = TAG_W'(dest);
  endtask

  task automatic cdb(input logic v, input int tag, input int value);
    cdb_valid_in = v;
    cdb_tag_in   = TAG_W'(tag);
    cdb_value_in = DATA_W'(value);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0;
    alloc_valid_in = 1'b0; issue_ready_in = 1'b0;
    put(0, 0, 0, 0, 0, 0); alloc_valid_in = 1'b0;
    cdb(1'b0, 0, 0);
    #3;
    chk("rst_count", count_out, 0);
    chk("rst_issue_valid", issue_valid_out, 0);
    chk("rst_alloc_ready", alloc_ready_out, 1);
    chk("rst_almost_full", almost_full_out, 0);
    step();
    rst_in = 1'b0;

    // Single ready alloc issues the following cycle.
    put(3, 0, 0, 5, 7, 2);
    step();
    alloc_valid_in = 1'b0;
    settle();
    chk("t1_valid", issue_valid_out, 1);
    chk("t1_op", issue_op_out, 3);
    chk("t1_vj", issue_vj_out, 5);
    chk("t1_vk", issue_vk_out, 7);
    chk("t1_dest", issue_dest_out, 2);
    chk("t1_count", count_out, 1);
    issue_ready_in = 1'b1;
    step();
    issue_ready_in = 1'b0;
    settle();
    chk("t1_count_after", count_out, 0);
    chk("t1_valid_after", issue_valid_out, 0);

    // Age ordering: B (slot 1) is older than C (slot 0).
    put(1, 4, 0, 0, 9, 1);       // A -> slot 0, waits on tag 4
    step();
    put(1, 0, 0, 2, 2, 2);       // B -> slot 1, ready
    step();
    alloc_valid_in = 1'b0;
    settle();
    chk("t2_only_b", issue_dest_out, 2);
    cdb(1'b1, 4, 32'h11);
    step();
    cdb(1'b0, 0, 0);
    settle();
    chk("t2_a_oldest", issue_dest_out, 1);
    chk("t2_a_vj", issue_vj_out, 32'h11);
    issue_ready_in = 1'b1;
    step();
    issue_ready_in = 1'b0;
    put(1, 0, 0, 3, 3, 3);       // C -> slot 0, ready
    step();
    alloc_valid_in = 1'b0;
    settle();
    chk("t2_count", count_out, 2);
    chk("t2_b_before_c", issue_dest_out, 2);
    issue_ready_in = 1'b1;
    step();
    settle();
    chk("t2_c_next", issue_dest_out, 3);
    step();
    issue_ready_in = 1'b0;
    settle();
    chk("t2_empty", count_out, 0);

    // CDB wakeup and alloc bypass.
    put(4, 0, 6, 1, 0, 5);
    step();
    alloc_valid_in = 1'b0;
    settle();
    chk("t3_waiting", issue_valid_out, 0);
    cdb(1'b1, 6, 32'hDEAD);
    put(4, 6, 0, 0, 2, 7);
    settle();
    chk("t3_same_cycle_not_ready", issue_valid_out, 0);
    step();
    cdb(1'b0, 0, 0);
    alloc_valid_in = 1'b0;
    settle();
    chk("t3_woken_valid", issue_valid_out, 1);
    chk("t3_woken_dest", issue_dest_out, 5);
    chk("t3_woken_vk", issue_vk_out, 32'hDEAD);
    issue_ready_in = 1'b1;
    step();
    settle();
    chk("t3_bypass_dest", issue_dest_out, 7);
    chk("t3_bypass_vj", issue_vj_out, 32'hDEAD);
    step();
    issue_ready_in = 1'b0;
    settle();
    chk("t3_empty", count_out, 0);

    // Fill to DEPTH-1, then alloc+issue together, then fill completely.
    put(1, 0, 0, 32'h100, 0, 1);
    step();
    for (int i = 1; i < DEPTH - 1; i++) begin
      put(2, 9, 0, 0, 0, i + 1);
      step();
    end
    alloc_valid_in = 1'b0;
    settle();
    chk("t4_count_m1", count_out, DEPTH - 1);
    chk("t4_almost_full", almost_full_out, 1);
    chk("t4_ready_m1", alloc_ready_out, 1);
    chk("t4_head_dest", issue_dest_out, 1);
    put(2, 9, 0, 0, 0, 0);
    issue_ready_in = 1'b1;
    step();
    alloc_valid_in = 1'b0;
    issue_ready_in = 1'b0;
    settle();
    chk("t4_alloc_issue_net0", count_out, DEPTH - 1);
    chk("t4_none_ready", issue_valid_out, 0);
    put(2, 9, 0, 0, 0, 0);
    step();
    settle();
    chk("t4_count_full", count_out, DEPTH);
    chk("t4_ready_full", alloc_ready_out, 0);
    chk("t4_almost_full_at_depth", almost_full_out, 0);
    step();
    alloc_valid_in = 1'b0;
    settle();
    chk("t4_no_overflow", count_out, DEPTH);

    // Flush a full station with every entry ready.
    cdb(1'b1, 9, 32'h99);
    step();
    cdb(1'b0, 0, 0);
    settle();
    chk("t5_valid_before", issue_valid_out, 1);
    chk("t5_oldest_dest", issue_dest_out, 2);
    chk("t5_oldest_vj", issue_vj_out, 32'h99);
    flush_in = 1'b1;
    issue_ready_in = 1'b1;
    put(1, 0, 0, 0, 0, 15);
    settle();
    chk("t5_valid_during_flush", issue_valid_out, 0);
    step();
    flush_in = 1'b0;
    issue_ready_in = 1'b0;
    alloc_valid_in = 1'b0;
    settle();
    chk("t5_count", count_out, 0);
    chk("t5_valid_after", issue_valid_out, 0);
    chk("t5_alloc_ready", alloc_ready_out, 1);
    step();
    chk("t5_count_stays", count_out, 0);

    // Global hold: CDB and alloc ignored while rdy_in is low.
    put(1, 8, 0, 0, 0, 1);
    step();
    put(1, 8, 0, 0, 0, 2);
    step();
    put(1, 0, 0, 0, 0, 4);
    step();
    alloc_valid_in = 1'b0;
    settle();
    chk("t6_count3", count_out, 3);
    chk("t6_dest4", issue_dest_out, 4);
    rdy_in = 1'b0;
    cdb(1'b1, 8, 32'h88);
    put(1, 0, 0, 0, 0, 5);
    issue_ready_in = 1'b1;
    settle();
    chk("t6_hold_valid", issue_valid_out, 0);
    step(); step(); step();
    rdy_in = 1'b1;
    cdb(1'b0, 0, 0);
    alloc_valid_in = 1'b0;
    issue_ready_in = 1'b0;
    settle();
    chk("t6_hold_count", count_out, 3);
    chk("t6_hold_valid_after", issue_valid_out, 1);
    chk("t6_tags_unchanged", issue_dest_out, 4);

    // Asynchronous reset with five entries held.
    put(1, 8, 0, 0, 0, 6);
    step();
    put(1, 8, 0, 0, 0, 7);
    step();
    alloc_valid_in = 1'b0;
    settle();
    chk("t7_count5", count_out, 5);
    #2;
    rst_in = 1'b1;
    #1;
    chk("t7_rst_count", count_out, 0);
    chk("t7_rst_valid", issue_valid_out, 0);
    chk("t7_rst_alloc_ready", alloc_ready_out, 1);
    chk("t7_rst_almost_full", almost_full_out, 0);
    step();
    rst_in = 1'b0;
    step();
    chk("t7_post_count", count_out, 0);
    chk("t7_post_valid", issue_valid_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rs_age_station.md
Name: rs_age_station

Overview:
- Parametrised reservation-station core. Generalises the fixed 16-entry, lowest-index-first RS helpers to DEPTH entries with oldest-first issue selection.
- Holds operand tags and values, captures CDB broadcasts, and issues the oldest ready entry through a valid/ready handshake.
- Sits between dispatch and one execution unit: ALU RS and branch RS instantiate it; LSB uses its selector.

Parameters:
DEPTH, 16, number of entries (power of two not required, 2..32)
TAG_W, 4, ROB tag width; tag value 0 means "operand available"
DATA_W, 32, operand width
OP_W, 5, opcode/control field width

Ports:
clk_in  input  1  clock
rst_in  input  1  asynchronous reset, active-high
rdy_in  input  1  global enable; low = hold all state
flush_in  input  1  misprediction flush; clears every entry
alloc_valid_in  input  1  dispatch presents an instruction
alloc_ready_out  output  1  station can accept (count_out < DEPTH)
alloc_op_in  input  OP_W  opcode
alloc_qj_in / alloc_qk_in  input  TAG_W  source tags
alloc_vj_in / alloc_vk_in  input  DATA_W  source values (valid when tag 0)
alloc_dest_in  input  TAG_W  destination ROB tag
cdb_valid_in  input  1  CDB broadcast valid
cdb_tag_in  input  TAG_W  broadcast tag (never 0)
cdb_value_in  input  DATA_W  broadcast value
issue_valid_out  output  1  selected entry valid
issue_ready_in  input  1  execution unit accepts
issue_op_out  output  OP_W  selected opcode
issue_vj_out / issue_vk_out  output  DATA_W  selected operands
issue_dest_out  output  TAG_W  selected destination tag
count_out  output  $clog2(DEPTH+1)  occupied entries
almost_full_out  output  1  exactly one vacancy

Behaviour:
- Reset (async): all busy=0, age matrix=0, count_out=0, issue_valid_out=0, almost_full_out=0, alloc_ready_out=1.
- Precedence per edge, when rdy_in=1: flush > issue-dequeue/alloc/wakeup.
  - flush_in=1: all busy cleared, age cleared, count_out=0 next cycle; alloc and issue in that cycle discarded.
- rdy_in=0: no state change; issue_valid_out forced 0; alloc ignored.
- Alloc (alloc_valid_in & alloc_ready_out): entry written into the lowest-index vacant slot k.
  - Age update: row k cleared; column k set for every other busy entry, making k youngest.
  - alloc_ready_out uses registered count only; a slot freed by a same-cycle issue is not counted.
- Wakeup: for every busy entry with qj==cdb_tag_in (resp. qk), capture the value and set the tag to 0 at the edge.
  - Alloc bypass: an alloc tag matching a same-cycle CDB is stored as tag 0 with cdb_value_in.
- Ready(i) = busy & qj==0 & qk==0, based on registered state. A same-cycle CDB match does not make an entry ready until the next cycle.
- Select: combinational. Picks the ready entry i with no other ready j where older[j][i]=1. Exactly one winner or none.
  - issue_* outputs are driven from the winner; issue_valid_out = any ready & rdy_in & ~flush_in.
- Dequeue on issue_valid_out & issue_ready_in: winner busy cleared; its age row and column ignored thereafter.
- Latency:
  - Alloc with both tags 0 in cycle t -> issue_valid_out in t+1.
  - CDB wakeup in cycle t -> issuable in t+1.
- Outputs stay stable while issue_valid_out=1 and issue_ready_in=0, unless an older entry becomes ready (oldest-first is the invariant, not stickiness).
- Count: +alloc, -dequeue, both in one cycle nets 0; never exceeds DEPTH or goes below 0.

Decomposition:
- Package rs_pkg:
  - TAG_NONE=0
  - tag, data and op typedefs sized from TAG_W/DATA_W/OP_W
  - rs_entry_t struct {busy, op, qj, qk, vj, vk, dest}
- Sub-module rs_age_select (DEPTH-parametrised): input ready vector and age matrix; output one-hot grant, binary index, has_grant.
- Vacancy search uses a parametrised lowest-index priority encoder in rs_common.

Test Plan:
- Reset, then alloc op=3, qj=qk=0, vj=5, vk=7, dest=2 -> next cycle issue_valid_out=1, vj=5, vk=7, dest=2; count_out=1 -> 0 after handshake.
- Alloc A (dest=1, qj=4) into slot 0, then B (dest=2, ready) into slot 1; free slot 0 via issue; alloc C (dest=3, ready) into slot 0 -> B issues before C despite higher index.
- Entry waiting on qk=6; cdb_tag_in=6, value=0xDEAD -> issue next cycle with vk=0xDEAD; alloc with qj=6 in the same CDB cycle -> stored ready with vj=0xDEAD.
- Fill DEPTH entries -> alloc_ready_out=0, almost_full_out=0 at DEPTH, almost_full_out=1 at DEPTH-1; simultaneous alloc+issue when count=DEPTH-1 -> count stays DEPTH-1.
- Full station, flush_in=1 with alloc_valid_in=1 and issue_ready_in=1 -> count_out=0, issue_valid_out=0 next cycle, no entry allocated.
- rst_in pulsed mid-operation with 5 entries busy -> all outputs at reset values immediately (asynchronous); rdy_in=0 for 3 cycles with a CDB broadcast -> tags unchanged afterwards.
